// File: rtl/simd_vec_seq_if.sv
// Command handshake, scratchpad strobes and lane op select for the SIMD vector sequencer.
// The master side drives commands and stall; the sequencer is the slave.
interface simd_vec_seq_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int OP_SEL_WIDTH = 2
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [OP_SEL_WIDTH-1:0] cmd_op;
  logic [ADDR_WIDTH-1:0]   cmd_src_a;
  logic [ADDR_WIDTH-1:0]   cmd_src_b;
  logic [ADDR_WIDTH-1:0]   cmd_dst;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic                    stall;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr_a;
  logic [ADDR_WIDTH-1:0]   rd_addr_b;
  logic [OP_SEL_WIDTH-1:0] pe_op;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    busy;
  logic                    done;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, stall,
    input  cmd_ready, rd_en, rd_addr_a, rd_addr_b, pe_op, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, stall,
    output cmd_ready, rd_en, rd_addr_a, rd_addr_b, pe_op, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/simd_vec_seq.sv
// Vector-op sequencer: walks the scratchpad one word per cycle, pairing reads with a
// delayed write-back and holding both under stall. Lanes stay purely combinational.
module simd_vec_seq #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int OP_SEL_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  simd_vec_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [OP_SEL_WIDTH-1:0] op_q;
  logic [ADDR_WIDTH-1:0]   src_a_q, src_b_q, dst_q;
  logic [LEN_WIDTH-1:0]    len_q, idx_q, wr_idx_q;
  logic                    wr_pend_q;

  logic accept, last_rd;
  logic cmd_ready, busy, done, rd_fire, wr_fire;

  assign accept  = bus.cmd_valid && cmd_ready;
  assign last_rd = (idx_q == len_q - LEN_WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every register in the design samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps this combinational block latch-free.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept) state_d = (bus.cmd_len == '0) ? ST_FIN : ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN:   if (rd_fire && last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_fire)            state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic; a read only fires when stall is low, so a stalled pending
  // write can never be overwritten by a new read.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_fire   = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_RUN: begin
        busy    = 1'b1;
        rd_fire = !bus.stall;
      end
      ST_DRAIN: busy = 1'b1;
      ST_FIN: begin
        cmd_ready = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
    wr_fire = wr_pend_q && !bus.stall;
  end

  // Command capture, read index and the single pending write slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_idx_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.cmd_op;
        src_a_q <= bus.cmd_src_a;
        src_b_q <= bus.cmd_src_b;
        dst_q   <= bus.cmd_dst;
        len_q   <= bus.cmd_len;
        idx_q   <= '0;
      end else if (rd_fire) begin
        idx_q <= idx_q + LEN_WIDTH'(1);
      end

      if (rd_fire) begin
        wr_pend_q <= 1'b1;
        wr_idx_q  <= idx_q;
      end else if (wr_fire) begin
        wr_pend_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = rd_fire;
  assign bus.wr_en     = wr_fire;
  assign bus.pe_op     = op_q;
  assign bus.rd_addr_a = src_a_q + ADDR_WIDTH'(idx_q);
  assign bus.rd_addr_b = src_b_q + ADDR_WIDTH'(idx_q);
  assign bus.wr_addr   = dst_q + ADDR_WIDTH'(wr_idx_q);

endmodule

// File: tb/tb_simd_vec_seq.sv
// Scoreboard bench for simd_vec_seq: expected read/write/done events are queued with
// their cycle numbers at command issue and matched by a negedge monitor.
module tb_simd_vec_seq;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int OW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_vec_seq_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .OP_SEL_WIDTH(OW)) sif ();

  simd_vec_seq #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .OP_SEL_WIDTH(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  typedef struct {
    int          cyc;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];
  bit      busy_map[int];

  int          cyc     = 0;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [OW-1:0] exp_op = '0;
  bit          mon_en  = 1'b0;

  rd_exp_t m_re;
  wr_exp_t m_we;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle-accurate monitor against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      check("rdy_vs_busy", {31'd0, sif.cmd_ready}, {31'd0, !sif.busy});
      check("busy", {31'd0, sif.busy}, {31'd0, busy_map.exists(cyc)});
      check("pe_op", {30'd0, sif.pe_op}, {30'd0, exp_op});

      if (sif.rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", {31'd0, sif.rd_en}, 32'd0);
        else begin
          m_re = rd_q.pop_front();
          check("rd_cyc", cyc, m_re.cyc);
          check("rd_addr_a", {24'd0, sif.rd_addr_a}, {24'd0, m_re.a});
          check("rd_addr_b", {24'd0, sif.rd_addr_b}, {24'd0, m_re.b});
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        check("rd_missing", {31'd0, sif.rd_en}, 32'd1);
        void'(rd_q.pop_front());
      end

      if (sif.wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", {31'd0, sif.wr_en}, 32'd0);
        else begin
          m_we = wr_q.pop_front();
          check("wr_cyc", cyc, m_we.cyc);
          check("wr_addr", {24'd0, sif.wr_addr}, {24'd0, m_we.addr});
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        check("wr_missing", {31'd0, sif.wr_en}, 32'd1);
        void'(wr_q.pop_front());
      end

      if (sif.done) begin
        if (done_q.size() == 0) check("done_unexpected", {31'd0, sif.done}, 32'd0);
        else check("done_cyc", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check("done_missing", {31'd0, sif.done}, 32'd1);
        void'(done_q.pop_front());
      end
    end
  end

  // Stall-free schedule: read k at acc+1+k, write k one cycle later, done at acc+len+2
  // (acc+1 for len 0). Events at or beyond relative cycle 'limit' are not expected.
  task automatic expect_plain(input int acc, input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [AW-1:0] d, input int len, input int limit);
    int done_rel;
    for (int k = 0; k < len; k++) begin
      if (k + 1 < limit) rd_q.push_back('{cyc: acc + 1 + k, a: a + AW'(k), b: b + AW'(k)});
      if (k + 2 < limit) wr_q.push_back('{cyc: acc + 2 + k, addr: d + AW'(k)});
    end
    done_rel = (len == 0) ? 1 : len + 2;
    for (int r = 1; r < done_rel && r < limit; r++) busy_map[acc + r] = 1'b1;
    if (done_rel < limit) done_q.push_back(acc + done_rel);
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [LW-1:0] len, output int acc);
    int t = 0;
    @(negedge clk);
    while (!sif.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("issue_ready", {31'd0, sif.cmd_ready}, 32'd1);
    sif.cmd_op    = op;
    sif.cmd_src_a = a;
    sif.cmd_src_b = b;
    sif.cmd_dst   = d;
    sif.cmd_len   = len;
    sif.cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    sif.cmd_valid = 1'b0;
    exp_op = op;
  endtask

  task automatic wait_empty();
    int t = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("sb_empty", rd_q.size() + wr_q.size() + done_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc, acc1, acc2, got;
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = '0;
    sif.cmd_src_a = '0;
    sif.cmd_src_b = '0;
    sif.cmd_dst   = '0;
    sif.cmd_len   = '0;
    sif.stall     = 1'b0;

    // Reset state
    #12;
    check("rst_rd_en", {31'd0, sif.rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, sif.wr_en}, 32'd0);
    check("rst_busy", {31'd0, sif.busy}, 32'd0);
    check("rst_done", {31'd0, sif.done}, 32'd0);
    check("rst_ready", {31'd0, sif.cmd_ready}, 32'd1);
    check("rst_pe_op", {30'd0, sif.pe_op}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic add
    issue(2'b01, 8'h10, 8'h20, 8'h30, 8'd4, acc);
    expect_plain(acc, 8'h10, 8'h20, 8'h30, 4, 1000);
    wait_empty();

    // Zero length, with stall held high to show it has no effect in IDLE/FIN
    sif.stall = 1'b1;
    issue(2'b10, 8'h55, 8'h66, 8'h77, 8'd0, acc);
    expect_plain(acc, 8'h55, 8'h66, 8'h77, 0, 1000);
    wait_empty();
    sif.stall = 1'b0;

    // Stall in cycles 2-3 of a len=3 command
    issue(2'b11, 8'h40, 8'h50, 8'h60, 8'd3, acc);
    rd_q.push_back('{cyc: acc + 1, a: 8'h40, b: 8'h50});
    rd_q.push_back('{cyc: acc + 4, a: 8'h41, b: 8'h51});
    rd_q.push_back('{cyc: acc + 5, a: 8'h42, b: 8'h52});
    wr_q.push_back('{cyc: acc + 4, addr: 8'h60});
    wr_q.push_back('{cyc: acc + 5, addr: 8'h61});
    wr_q.push_back('{cyc: acc + 6, addr: 8'h62});
    done_q.push_back(acc + 7);
    for (int r = 1; r <= 6; r++) busy_map[acc + r] = 1'b1;
    @(posedge clk); #1; sif.stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1; sif.stall = 1'b0;
    wait_empty();

    // Address wrap
    issue(2'b01, 8'hFE, 8'h00, 8'hFF, 8'd4, acc);
    expect_plain(acc, 8'hFE, 8'h00, 8'hFF, 4, 1000);
    wait_empty();

    // Reset in cycle 4 of a len=8 command
    issue(2'b01, 8'h80, 8'h90, 8'hA0, 8'd8, acc);
    expect_plain(acc, 8'h80, 8'h90, 8'hA0, 8, 4);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    exp_op = '0;
    busy_map.delete();
    #1;
    check("arst_rd_en", {31'd0, sif.rd_en}, 32'd0);
    check("arst_wr_en", {31'd0, sif.wr_en}, 32'd0);
    check("arst_busy", {31'd0, sif.busy}, 32'd0);
    check("arst_pe_op", {30'd0, sif.pe_op}, 32'd0);
    check("arst_rd_addr_a", {24'd0, sif.rd_addr_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, sif.cmd_ready}, 32'd1);
    check("post_rst_sb", rd_q.size() + wr_q.size() + done_q.size(), 32'd0);
    issue(2'b10, 8'h80, 8'h90, 8'hA0, 8'd3, acc);
    expect_plain(acc, 8'h80, 8'h90, 8'hA0, 3, 1000);
    wait_empty();

    // Back-to-back: cmd_valid held, second command taken in the first one's FIN cycle
    @(negedge clk);
    sif.cmd_op    = 2'b01;
    sif.cmd_src_a = 8'h00;
    sif.cmd_src_b = 8'h08;
    sif.cmd_dst   = 8'h10;
    sif.cmd_len   = 8'd2;
    sif.cmd_valid = 1'b1;
    acc1 = cyc;
    acc2 = acc1 + 4;
    expect_plain(acc1, 8'h00, 8'h08, 8'h10, 2, 1000);
    expect_plain(acc2, 8'hC0, 8'hD0, 8'hE0, 2, 1000);
    @(posedge clk);
    #1;
    exp_op        = 2'b01;
    sif.cmd_op    = 2'b11;
    sif.cmd_src_a = 8'hC0;
    sif.cmd_src_b = 8'hD0;
    sif.cmd_dst   = 8'hE0;
    got = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (sif.cmd_ready) begin
        got = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    sif.cmd_valid = 1'b0;
    exp_op        = 2'b11;
    check("b2b_accept_cyc", got, acc2);
    wait_empty();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
